// File: rtl/bru_resolve_unit.sv
// rtl/bru_resolve_unit.sv - pipelined AArch64 branch resolution unit
// In-order uop FIFO feeding a registered resolve stage with ROB, BL link, redirect and perf outputs.
module bru_resolve_unit #(
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = 6,
  parameter int PREG_W    = 7,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [3:0]           in_cond,
  input  logic [3:0]           in_nzcv,
  input  logic [63:0]          in_pc,
  input  logic [63:0]          in_imm,
  input  logic [63:0]          in_rn_val,
  input  logic                 in_sf,
  input  logic                 in_pred_taken,
  input  logic [63:0]          in_pred_target,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [PREG_W-1:0]    in_dest_phys,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ROB_IDX_W-1:0] res_rob_idx,
  output logic                 res_taken,
  output logic [63:0]          res_target,
  output logic                 res_mispredict,
  output logic                 wb_en,
  output logic [PREG_W-1:0]    wb_index,
  output logic [63:0]          wb_data,
  output logic                 redirect_valid,
  output logic [63:0]          redirect_pc,
  output logic [CNT_W-1:0]     stat_branches,
  output logic [CNT_W-1:0]     stat_mispred
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [2:0] OP_B     = 3'd0;
  localparam logic [2:0] OP_BL    = 3'd1;
  localparam logic [2:0] OP_BCOND = 3'd2;
  localparam logic [2:0] OP_CBZ   = 3'd3;
  localparam logic [2:0] OP_CBNZ  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;

  typedef struct packed {
    logic [2:0]           op;
    logic [3:0]           cond;
    logic [3:0]           nzcv;
    logic [63:0]          pc;
    logic [63:0]          imm;
    logic [63:0]          rn_val;
    logic                 sf;
    logic                 pred_taken;
    logic [63:0]          pred_target;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    dest_phys;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;

  logic                 r_res_valid;
  logic [ROB_IDX_W-1:0] r_res_rob_idx;
  logic                 r_res_taken;
  logic [63:0]          r_res_target;
  logic                 r_res_mispredict;
  logic                 r_res_is_bl;
  logic [PREG_W-1:0]    r_wb_index;
  logic [63:0]          r_wb_data;
  logic [CNT_W-1:0]     r_stat_branches;
  logic [CNT_W-1:0]     r_stat_mispred;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_handoff;
  logic                 w_mp_handoff;
  logic                 w_push;
  logic                 w_pop;
  entry_t               w_head;
  entry_t               w_in_entry;

  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign in_ready = !w_full && !flush;

  // A mispredicted handoff makes every younger uop wrong-path, including one arriving this cycle.
  assign w_handoff    = r_res_valid && res_ready && !flush;
  assign w_mp_handoff = w_handoff && r_res_mispredict;
  assign w_push       = in_valid && in_ready && !w_mp_handoff;
  assign w_pop        = !w_empty && (!r_res_valid || res_ready) && !flush && !w_mp_handoff;

  assign w_in_entry = '{op: in_op, cond: in_cond, nzcv: in_nzcv, pc: in_pc, imm: in_imm,
                        rn_val: in_rn_val, sf: in_sf, pred_taken: in_pred_taken,
                        pred_target: in_pred_target, rob_idx: in_rob_idx,
                        dest_phys: in_dest_phys};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_in_entry;
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_base;
  logic        w_cond_taken;
  logic        w_test_zero;
  logic [63:0] w_pc4;
  logic [63:0] w_br_target;
  logic [63:0] w_ret_target;
  logic        w_taken;
  logic        w_legal;
  logic [63:0] w_taken_target;
  logic [63:0] w_res_target;
  logic        w_mispredict;

  assign {w_n, w_z, w_c, w_v} = w_head.nzcv;

  assign w_pc4        = w_head.pc + 64'd4;
  assign w_br_target  = w_head.pc + (w_head.imm << 2);
  assign w_ret_target = w_head.rn_val & ~64'h3;
  assign w_test_zero  = w_head.sf ? (w_head.rn_val == 64'd0) : (w_head.rn_val[31:0] == 32'd0);

  // cond[0] inverts the base test, except for the AL/NV pair which is always taken.
  always_comb begin
    w_cond_base = 1'b1;
    case (w_head.cond[3:1])
      3'd0:    w_cond_base = w_z;
      3'd1:    w_cond_base = w_c;
      3'd2:    w_cond_base = w_n;
      3'd3:    w_cond_base = w_v;
      3'd4:    w_cond_base = w_c && !w_z;
      3'd5:    w_cond_base = (w_n == w_v);
      3'd6:    w_cond_base = !w_z && (w_n == w_v);
      default: w_cond_base = 1'b1;
    endcase
    w_cond_taken = (w_head.cond[0] && (w_head.cond[3:1] != 3'b111)) ? !w_cond_base : w_cond_base;
  end

  always_comb begin
    w_taken        = 1'b0;
    w_legal        = 1'b1;
    w_taken_target = w_br_target;
    case (w_head.op)
      OP_B, OP_BL: w_taken = 1'b1;
      OP_BCOND:    w_taken = w_cond_taken;
      OP_CBZ:      w_taken = w_test_zero;
      OP_CBNZ:     w_taken = !w_test_zero;
      OP_RET: begin
        w_taken        = 1'b1;
        w_taken_target = w_ret_target;
      end
      default:     w_legal = 1'b0;
    endcase
  end

  assign w_res_target = w_taken ? w_taken_target : w_pc4;
  assign w_mispredict = !w_legal ? w_head.pred_taken :
                        ((w_taken != w_head.pred_taken) ||
                         (w_taken && (w_taken_target != w_head.pred_target)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_res_valid      <= 1'b0;
      r_res_rob_idx    <= '0;
      r_res_taken      <= 1'b0;
      r_res_target     <= '0;
      r_res_mispredict <= 1'b0;
      r_res_is_bl      <= 1'b0;
      r_wb_index       <= '0;
      r_wb_data        <= '0;
      r_stat_branches  <= '0;
      r_stat_mispred   <= '0;
    end else begin
      if (flush || w_mp_handoff) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (flush || w_mp_handoff) begin
        r_res_valid <= 1'b0;
      end else if (w_pop) begin
        r_res_valid      <= 1'b1;
        r_res_rob_idx    <= w_head.rob_idx;
        r_res_taken      <= w_taken;
        r_res_target     <= w_res_target;
        r_res_mispredict <= w_mispredict;
        r_res_is_bl      <= (w_head.op == OP_BL);
        r_wb_index       <= w_head.dest_phys;
        r_wb_data        <= w_pc4;
      end else if (w_handoff) begin
        r_res_valid <= 1'b0;
      end

      if (w_handoff) begin
        r_stat_branches <= r_stat_branches + 1'b1;
        if (r_res_mispredict) r_stat_mispred <= r_stat_mispred + 1'b1;
      end
    end
  end

  assign res_valid      = r_res_valid;
  assign res_rob_idx    = r_res_rob_idx;
  assign res_taken      = r_res_taken;
  assign res_target     = r_res_target;
  assign res_mispredict = r_res_mispredict;
  assign wb_en          = w_handoff && r_res_is_bl;
  assign wb_index       = r_wb_index;
  assign wb_data        = r_wb_data;
  assign redirect_valid = w_mp_handoff;
  assign redirect_pc    = r_res_target;
  assign stat_branches  = r_stat_branches;
  assign stat_mispred   = r_stat_mispred;

endmodule

// File: tb/tb_bru_resolve_unit.sv
// tb/tb_bru_resolve_unit.sv - scoreboard bench for bru_resolve_unit
// Driver pushes hand-computed expectations on accept; negedge monitor compares every handoff.
module tb_bru_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_cond;
  logic [3:0]  in_nzcv;
  logic [63:0] in_pc;
  logic [63:0] in_imm;
  logic [63:0] in_rn_val;
  logic        in_sf;
  logic        in_pred_taken;
  logic [63:0] in_pred_target;
  logic [5:0]  in_rob_idx;
  logic [6:0]  in_dest_phys;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_rob_idx;
  logic        res_taken;
  logic [63:0] res_target;
  logic        res_mispredict;
  logic        wb_en;
  logic [6:0]  wb_index;
  logic [63:0] wb_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  bru_resolve_unit #(.DEPTH(4), .ROB_IDX_W(6), .PREG_W(7), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_nzcv(in_nzcv), .in_pc(in_pc), .in_imm(in_imm),
    .in_rn_val(in_rn_val), .in_sf(in_sf), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .in_rob_idx(in_rob_idx), .in_dest_phys(in_dest_phys),
    .res_valid(res_valid), .res_ready(res_ready), .res_rob_idx(res_rob_idx),
    .res_taken(res_taken), .res_target(res_target), .res_mispredict(res_mispredict),
    .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  rob;
    logic        taken;
    logic [63:0] target;
    logic        mp;
    logic        is_bl;
    logic [63:0] wb_data;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready && !flush) begin
        if (q.size() == 0) begin
          chk("unexpected_handoff_rob", {58'd0, res_rob_idx}, 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("res_rob_idx", {58'd0, res_rob_idx}, {58'd0, e.rob});
          chk("res_taken", {63'd0, res_taken}, {63'd0, e.taken});
          chk("res_target", res_target, e.target);
          chk("res_mispredict", {63'd0, res_mispredict}, {63'd0, e.mp});
          chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.mp});
          if (e.mp) chk("redirect_pc", redirect_pc, e.target);
          chk("wb_en", {63'd0, wb_en}, {63'd0, e.is_bl});
          if (e.is_bl) begin
            chk("wb_index", {57'd0, wb_index}, 64'd17);
            chk("wb_data", wb_data, e.wb_data);
          end
        end
      end else begin
        chk("idle_wb_en", {63'd0, wb_en}, 64'd0);
        chk("idle_redirect", {63'd0, redirect_valid}, 64'd0);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [3:0] cond, input logic [3:0] nzcv,
                       input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rn,
                       input logic sf, input logic pt, input logic [63:0] ptgt,
                       input logic [5:0] rob);
    in_op = op; in_cond = cond; in_nzcv = nzcv; in_pc = pc; in_imm = imm; in_rn_val = rn;
    in_sf = sf; in_pred_taken = pt; in_pred_target = ptgt; in_rob_idx = rob;
    in_dest_phys = 7'd17;
  endtask

  // Offer one uop until accepted, then record its hand-computed expectation.
  task automatic send(input logic [2:0] op, input logic [3:0] cond, input logic [3:0] nzcv,
                      input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rn,
                      input logic sf, input logic pt, input logic [63:0] ptgt,
                      input logic [5:0] rob, input logic et, input logic [63:0] etgt,
                      input logic emp);
    exp_t e;
    bit   ok;
    drive(op, cond, nzcv, pc, imm, rn, sf, pt, ptgt, rob);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_accept_timeout", 64'd0, 64'd1);
    else begin
      e.rob = rob; e.taken = et; e.target = etgt; e.mp = emp;
      e.is_bl = (op == 3'd1); e.wb_data = pc + 64'd4;
      q.push_back(e);
    end
  endtask

  // Burst entry i: correctly predicted B, target pc + (i+1)*4.
  task automatic drive_idx(input int i);
    logic [63:0] pc;
    pc = 64'h5000 + 64'(i) * 64'h100;
    drive(3'd0, 4'd0, 4'd0, pc, 64'(i + 1), 64'd0, 1'b0, 1'b1, pc + 64'(i + 1) * 64'd4, 6'(i));
  endtask

  task automatic offer(input int first, input int last, input bit record, input int cycles,
                       output int next);
    int  idx;
    bit  acc;
    exp_t e;
    idx = first;
    drive_idx(idx);
    in_valid = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (record) begin
          e.rob = 6'(idx); e.taken = 1'b1; e.mp = 1'b0; e.is_bl = 1'b0; e.wb_data = 64'd0;
          e.target = 64'h5000 + 64'(idx) * 64'h100 + 64'(idx + 1) * 64'd4;
          q.push_back(e);
        end
        idx++;
        if (idx < last) drive_idx(idx);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    next = idx;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nx;
    logic [31:0] s0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    drive(3'd0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 6'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_stat_branches", {32'd0, stat_branches}, 64'd0);
    chk("rst_stat_mispred", {32'd0, stat_mispred}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    rst = 1'b0;
    idle(2);

    // op cond nzcv pc imm rn sf pred_t pred_tgt rob | taken target mispredict
    send(3'd2, 4'b1100, 4'b0000, 64'h1000, 64'd4, 64'd0, 1'b0, 1'b0, 64'd0, 6'd1, 1'b1, 64'h1010, 1'b1); idle(4);
    send(3'd1, 4'd0, 4'd0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, 1'b1, 64'h1FF8, 6'd2, 1'b1, 64'h1FF8, 1'b0); idle(4);
    send(3'd3, 4'd0, 4'd0, 64'h3000, 64'd2, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 64'h3008, 6'd3, 1'b1, 64'h3008, 1'b0); idle(4);
    send(3'd3, 4'd0, 4'd0, 64'h3000, 64'd2, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 64'h3008, 6'd4, 1'b0, 64'h3004, 1'b1); idle(4);
    send(3'd4, 4'd0, 4'd0, 64'h3100, 64'h10, 64'd1, 1'b1, 1'b1, 64'h3140, 6'd5, 1'b1, 64'h3140, 1'b0); idle(4);
    send(3'd2, 4'b0001, 4'b0100, 64'h3200, 64'd8, 64'd0, 1'b0, 1'b0, 64'd0, 6'd6, 1'b0, 64'h3204, 1'b0); idle(4);
    send(3'd2, 4'b1101, 4'b1000, 64'h3300, 64'd3, 64'd0, 1'b0, 1'b1, 64'h3300, 6'd7, 1'b1, 64'h330C, 1'b1); idle(4);
    send(3'd2, 4'b1000, 4'b0010, 64'h3400, 64'd5, 64'd0, 1'b0, 1'b1, 64'h3414, 6'd8, 1'b1, 64'h3414, 1'b0); idle(4);
    send(3'd2, 4'b1111, 4'b0000, 64'h3500, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'h34FC, 6'd9, 1'b1, 64'h34FC, 1'b0); idle(4);
    send(3'd2, 4'b1011, 4'b0001, 64'h3600, 64'h40, 64'd0, 1'b0, 1'b0, 64'd0, 6'd10, 1'b1, 64'h3700, 1'b1); idle(4);
    send(3'd2, 4'b1010, 4'b0001, 64'h3700, 64'h40, 64'd0, 1'b0, 1'b0, 64'd0, 6'd11, 1'b0, 64'h3704, 1'b0); idle(4);
    send(3'd5, 4'd0, 4'd0, 64'h3800, 64'd0, 64'h4003, 1'b0, 1'b1, 64'h4000, 6'd12, 1'b1, 64'h4000, 1'b0); idle(4);
    send(3'd6, 4'd0, 4'd0, 64'h3900, 64'd0, 64'd0, 1'b0, 1'b1, 64'h1234, 6'd13, 1'b0, 64'h3904, 1'b1); idle(4);
    send(3'd7, 4'd0, 4'd0, 64'h3A00, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 6'd14, 1'b0, 64'h3A04, 1'b0); idle(4);
    send(3'd2, 4'b0010, 4'b0000, 64'h3B00, 64'd1, 64'd0, 1'b0, 1'b0, 64'd0, 6'd15, 1'b0, 64'h3B04, 1'b0); idle(4);
    send(3'd2, 4'b0100, 4'b1000, 64'h3C00, 64'd2, 64'd0, 1'b0, 1'b1, 64'h3C08, 6'd16, 1'b1, 64'h3C08, 1'b0); idle(4);
    send(3'd2, 4'b0111, 4'b0001, 64'h3D00, 64'd2, 64'd0, 1'b0, 1'b0, 64'd0, 6'd17, 1'b0, 64'h3D04, 1'b0); idle(4);
    send(3'd2, 4'b1001, 4'b0010, 64'h3E00, 64'd2, 64'd0, 1'b0, 1'b0, 64'd0, 6'd18, 1'b0, 64'h3E04, 1'b0); idle(4);
    chk("stat_branches_directed", {32'd0, stat_branches}, 64'd18);
    chk("stat_mispred_directed", {32'd0, stat_mispred}, 64'd5);

    // Backpressure: FIFO plus output register hold DEPTH+1 before in_ready drops.
    res_ready = 1'b0;
    offer(0, 6, 1'b1, 10, nx);
    chk("full_accept_count", 64'(nx), 64'd5);
    in_valid = 1'b1;
    drive_idx(nx);
    @(negedge clk);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    s0 = stat_branches;
    res_ready = 1'b1;
    offer(nx, 6, 1'b1, 5, nx);
    chk("drain_rate", {32'd0, stat_branches - s0}, 64'd5);
    chk("drain_last_accept", 64'(nx), 64'd6);
    idle(4);

    // Mispredict at head with three queued behind it.
    res_ready = 1'b0;
    send(3'd2, 4'b0000, 4'b0000, 64'h6000, 64'd4, 64'd0, 1'b0, 1'b1, 64'h6010, 6'd40, 1'b0, 64'h6004, 1'b1);
    offer(100, 103, 1'b0, 6, nx);
    chk("mp_queued", 64'(nx), 64'd103);
    s0 = stat_mispred;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mp_res_valid_cleared", {63'd0, res_valid}, 64'd0);
    chk("mp_stat_inc", {32'd0, stat_mispred - s0}, 64'd1);
    idle(3);
    chk("mp_fifo_empty", {63'd0, res_valid}, 64'd0);

    // Flush with a full queue and a uop on offer.
    res_ready = 1'b0;
    offer(200, 206, 1'b0, 10, nx);
    chk("flush_prefill", 64'(nx), 64'd205);
    s0 = stat_branches;
    drive_idx(205);
    in_valid = 1'b1; flush = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_res_valid", {63'd0, res_valid}, 64'd0);
    chk("flush_no_handoff", {32'd0, stat_branches - s0}, 64'd0);
    idle(3);
    chk("flush_nothing_accepted", {63'd0, res_valid}, 64'd0);

    chk("final_stat_branches", {32'd0, stat_branches}, 64'd25);
    chk("final_stat_mispred", {32'd0, stat_mispred}, 64'd6);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
